// File: rtl/execute_stage_pkg.sv
// execute_stage_pkg: shared encodings for the E stage.
//   - MIPS opcode/funct constants for every supported instruction
//   - multiply/divide latency constants
//   - ALU operation and MDU operation enumerations, decoded-control struct
//   - decode(): instruction word -> control struct
package execute_stage_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  localparam int unsigned MULT_CYC = 5;
  localparam int unsigned DIV_CYC  = 10;

  typedef enum logic [3:0] {
    ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT,
    ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_MFHI, ALU_MFLO
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MF
  } md_op_e;

  typedef struct packed {
    alu_op_e alu;
    logic    use_imm;    // second operand is imm32 instead of rt
    logic    var_shamt;  // shift amount from rs[4:0] instead of shamt field
    logic    ov_trap;    // overflow cancels the register write
    logic    ov_addr;    // overflow is an address overflow (load/store)
    md_op_e  md;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t d;
    d = '{ALU_NOP, 1'b0, 1'b0, 1'b0, 1'b0, MD_NONE};
    if (instr[31:26] == OP_SPECIAL) begin
      case (instr[5:0])
        FN_ADD:   begin d.alu = ALU_ADD; d.ov_trap = 1'b1; end
        FN_ADDU:  d.alu = ALU_ADD;
        FN_SUB:   begin d.alu = ALU_SUB; d.ov_trap = 1'b1; end
        FN_SUBU:  d.alu = ALU_SUB;
        FN_AND:   d.alu = ALU_AND;
        FN_OR:    d.alu = ALU_OR;
        FN_XOR:   d.alu = ALU_XOR;
        FN_NOR:   d.alu = ALU_NOR;
        FN_SLT:   d.alu = ALU_SLT;
        FN_SLTU:  d.alu = ALU_SLTU;
        FN_SLL:   d.alu = ALU_SLL;
        FN_SRL:   d.alu = ALU_SRL;
        FN_SRA:   d.alu = ALU_SRA;
        FN_SLLV:  begin d.alu = ALU_SLL; d.var_shamt = 1'b1; end
        FN_SRLV:  begin d.alu = ALU_SRL; d.var_shamt = 1'b1; end
        FN_SRAV:  begin d.alu = ALU_SRA; d.var_shamt = 1'b1; end
        FN_MFHI:  begin d.alu = ALU_MFHI; d.md = MD_MF; end
        FN_MFLO:  begin d.alu = ALU_MFLO; d.md = MD_MF; end
        FN_MTHI:  d.md = MD_MTHI;
        FN_MTLO:  d.md = MD_MTLO;
        FN_MULT:  d.md = MD_MULT;
        FN_MULTU: d.md = MD_MULTU;
        FN_DIV:   d.md = MD_DIV;
        FN_DIVU:  d.md = MD_DIVU;
        default:  ;
      endcase
    end else begin
      d.use_imm = 1'b1;
      case (instr[31:26])
        OP_ADDI:  begin d.alu = ALU_ADD; d.ov_trap = 1'b1; end
        OP_ADDIU: d.alu = ALU_ADD;
        OP_SLTI:  d.alu = ALU_SLT;
        OP_SLTIU: d.alu = ALU_SLTU;
        OP_ANDI:  d.alu = ALU_AND;
        OP_ORI:   d.alu = ALU_OR;
        OP_XORI:  d.alu = ALU_XOR;
        OP_LUI:   d.alu = ALU_LUI;
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW:
          begin d.alu = ALU_ADD; d.ov_addr = 1'b1; end
        default:  ;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/execute_stage_mdu.sv
// mdu: multi-cycle multiply/divide unit owning HI, LO, the cycle counter,
// Busy and the operand latches.
//   clk, reset    : clock, synchronous active-high reset (aborts any operation)
//   start         : launch op (mult/multu/div/divu) with operands a, b
//   op            : MDU operation of the instruction in E
//   mt_we         : commit mthi/mtlo (selected by op) from a
//   busy          : operation in flight
//   hi, lo        : architectural HI/LO
//
// state | meaning
// IDLE  | nothing in flight; HI/LO hold the last result
// RUN   | iterating; count = cycles left including the current one
module mdu
  import execute_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  md_op_e      op,
  input  logic        mt_we,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e      state, state_nxt;
  logic [3:0]  count, count_nxt;
  logic        done;
  logic [31:0] a_q, b_q;
  logic        is_div_q, is_signed_q;
  logic [63:0] prod;
  logic [31:0] mag_a, mag_b, uquo, urem, quo, rem;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      S_IDLE: if (start) begin
        state_nxt = S_RUN;
        count_nxt = (op == MD_DIV || op == MD_DIVU) ? 4'(DIV_CYC) : 4'(MULT_CYC);
      end
      S_RUN: begin
        count_nxt = count - 4'd1;
        if (count == 4'd1) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
    done = busy && (count == 4'd1);
  end

  // Sign-extend to 64 bits only for signed ops; the low 64 bits of the
  // product are then correct for both signednesses.
  // Division works on magnitudes so that -2^31 / -1 stays well defined.
  always_comb begin
    prod  = {{32{is_signed_q & a_q[31]}}, a_q} * {{32{is_signed_q & b_q[31]}}, b_q};
    mag_a = (is_signed_q & a_q[31]) ? -a_q : a_q;
    mag_b = (is_signed_q & b_q[31]) ? -b_q : b_q;
    uquo  = (mag_b != '0) ? mag_a / mag_b : '0;
    urem  = (mag_b != '0) ? mag_a % mag_b : '0;
    quo   = (is_signed_q & (a_q[31] ^ b_q[31])) ? -uquo : uquo;
    rem   = (is_signed_q & a_q[31]) ? -urem : urem;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q         <= '0;
      b_q         <= '0;
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      if (start) begin
        a_q         <= a;
        b_q         <= b;
        is_div_q    <= (op == MD_DIV) || (op == MD_DIVU);
        is_signed_q <= (op == MD_MULT) || (op == MD_DIV);
      end
      if (done) begin
        if (!is_div_q) begin
          {hi, lo} <= prod;
        end else if (b_q != '0) begin
          hi <= rem;
          lo <= quo;
        end
      end else if (mt_we) begin
        if (op == MD_MTHI) hi <= a;
        else               lo <= a;
      end
    end
  end

endmodule

// File: rtl/execute_stage.sv
// execute_stage: E stage of the pipeline -- ALU, overflow detection, MDU
// stall logic and the EX/MEM pipeline register.
//   clk, reset                       : clock, synchronous active-high reset
//   PC2, Instr2, A2, B2, imm32_2, WA2 : E-stage inputs (WA2=0: no write)
//   IntReq                           : flush request from M/CP0
//   PC3, Instr3, Result3, B3, imm32_3, WA3, Ov : EX/MEM register
//   Stall                            : freeze F/D (combinational)
//   Busy                             : MDU iterating (registered)
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC2,
  input  logic [31:0] Instr2,
  input  logic [31:0] A2,
  input  logic [31:0] B2,
  input  logic [31:0] imm32_2,
  input  logic [4:0]  WA2,
  input  logic        IntReq,
  output logic [31:0] PC3,
  output logic [31:0] Instr3,
  output logic [31:0] Result3,
  output logic [31:0] B3,
  output logic [31:0] imm32_3,
  output logic [4:0]  WA3,
  output logic        Stall,
  output logic        Busy,
  output logic        Ov
);

  dec_t        dec;
  logic [31:0] opb, result, hi, lo;
  logic [4:0]  sh;
  logic [32:0] sum_x, dif_x;
  logic        arith_ov, ov, start, mt_we, flush;

  always_comb begin
    dec   = decode(Instr2);
    opb   = dec.use_imm ? imm32_2 : B2;
    sh    = dec.var_shamt ? A2[4:0] : Instr2[10:6];
    // 33-bit sign-extended add/sub: overflow when the two top bits differ
    sum_x = {A2[31], A2} + {opb[31], opb};
    dif_x = {A2[31], A2} - {opb[31], opb};
    case (dec.alu)
      ALU_ADD:  result = sum_x[31:0];
      ALU_SUB:  result = dif_x[31:0];
      ALU_AND:  result = A2 & opb;
      ALU_OR:   result = A2 | opb;
      ALU_XOR:  result = A2 ^ opb;
      ALU_NOR:  result = ~(A2 | opb);
      ALU_SLT:  result = {31'b0, $signed(A2) < $signed(opb)};
      ALU_SLTU: result = {31'b0, A2 < opb};
      ALU_SLL:  result = B2 << sh;
      ALU_SRL:  result = B2 >> sh;
      ALU_SRA:  result = $signed(B2) >>> sh;
      ALU_LUI:  result = {opb[15:0], 16'h0000};
      ALU_MFHI: result = hi;
      ALU_MFLO: result = lo;
      default:  result = '0;
    endcase
    arith_ov = (dec.alu == ALU_SUB) ? (dif_x[32] ^ dif_x[31]) : (sum_x[32] ^ sum_x[31]);
    ov       = (dec.ov_trap | dec.ov_addr) & arith_ov;
  end

  // A Start for a different instruction cannot coincide with an MDU op in
  // E in an in-order pipe, so only Busy needs to hold the stage.
  always_comb begin
    Stall = (dec.md != MD_NONE) & Busy;
    flush = Stall | IntReq;
    start = (dec.md inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}) & ~Busy & ~IntReq & ~reset;
    mt_we = (dec.md inside {MD_MTHI, MD_MTLO}) & ~flush;
  end

  mdu u_mdu (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (dec.md),
    .mt_we (mt_we),
    .a     (A2),
    .b     (B2),
    .busy  (Busy),
    .hi    (hi),
    .lo    (lo)
  );

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      PC3     <= '0;
      Instr3  <= '0;
      Result3 <= '0;
      B3      <= '0;
      imm32_3 <= '0;
      WA3     <= '0;
      Ov      <= 1'b0;
    end else begin
      PC3     <= PC2;
      Instr3  <= Instr2;
      Result3 <= result;
      B3      <= B2;
      imm32_3 <= imm32_2;
      WA3     <= (dec.ov_trap & ov) ? 5'd0 : WA2;
      Ov      <= ov;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC2, Instr2, A2, B2, imm32_2;
  logic [4:0]  WA2;
  logic        IntReq;
  logic [31:0] PC3, Instr3, Result3, B3, imm32_3;
  logic [4:0]  WA3;
  logic        Stall, Busy, Ov;

  int checks   = 0;
  int failures = 0;
  logic [31:0] hi_m, lo_m;

  logic [5:0] r_fns [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                             6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
  logic [5:0] i_ops [10] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                             6'h23, 6'h2B};

  always #5 clk = ~clk;

  execute_stage dut (
    .clk(clk), .reset(reset), .PC2(PC2), .Instr2(Instr2), .A2(A2), .B2(B2),
    .imm32_2(imm32_2), .WA2(WA2), .IntReq(IntReq), .PC3(PC3), .Instr3(Instr3),
    .Result3(Result3), .B3(B3), .imm32_3(imm32_3), .WA3(WA3), .Stall(Stall),
    .Busy(Busy), .Ov(Ov)
  );

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rt(input logic [5:0] fn, input logic [4:0] shamt);
    return {6'h00, 15'h0000, shamt, fn};
  endfunction

  function automatic logic [31:0] it(input logic [5:0] op);
    return {op, 26'h0};
  endfunction

  task automatic drive(input logic [31:0] instr, a, b, imm, input logic [4:0] wa);
    Instr2 = instr; A2 = a; B2 = b; imm32_2 = imm; WA2 = wa; PC2 = $urandom;
  endtask

  // Reference ALU from the instruction-set definitions, in 64-bit arithmetic.
  function automatic void model(input logic [31:0] instr, a, b, imm,
                                output logic [31:0] r, output logic ov, output logic trap);
    longint sa, sb, si, s;
    logic chk_ov;
    sa = $signed(a); sb = $signed(b); si = $signed(imm);
    s = 0; r = '0; chk_ov = 0; trap = 0;
    if (instr[31:26] == 6'h00) begin
      case (instr[5:0])
        6'h20: begin s = sa + sb; chk_ov = 1; trap = 1; end
        6'h21: r = a + b;
        6'h22: begin s = sa - sb; chk_ov = 1; trap = 1; end
        6'h23: r = a - b;
        6'h24: r = a & b;
        6'h25: r = a | b;
        6'h26: r = a ^ b;
        6'h27: r = ~(a | b);
        6'h2A: r = (sa < sb) ? 1 : 0;
        6'h2B: r = (a < b) ? 1 : 0;
        6'h00: r = b << instr[10:6];
        6'h02: r = b >> instr[10:6];
        6'h03: begin s = sb >> instr[10:6]; r = s[31:0]; end
        6'h04: r = b << a[4:0];
        6'h06: r = b >> a[4:0];
        6'h07: begin s = sb >> a[4:0]; r = s[31:0]; end
        6'h10: r = hi_m;
        6'h12: r = lo_m;
        default: r = '0;
      endcase
    end else begin
      case (instr[31:26])
        6'h08: begin s = sa + si; chk_ov = 1; trap = 1; end
        6'h09: r = a + imm;
        6'h0A: r = (sa < si) ? 1 : 0;
        6'h0B: r = (a < imm) ? 1 : 0;
        6'h0C: r = a & imm;
        6'h0D: r = a | imm;
        6'h0E: r = a ^ imm;
        6'h0F: r = {imm[15:0], 16'h0};
        6'h23, 6'h2B: begin s = sa + si; chk_ov = 1; end
        default: r = '0;
      endcase
    end
    ov = 0;
    if (chk_ov) begin
      r  = s[31:0];
      ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end
  endfunction

  task automatic exec_alu(input string tag, input logic [31:0] instr, a, b, imm, input logic [4:0] wa);
    logic [31:0] r, pc;
    logic ov, trap;
    drive(instr, a, b, imm, wa);
    pc = PC2;
    model(instr, a, b, imm, r, ov, trap);
    step();
    chk(tag, {PC3, Instr3, Result3, B3, imm32_3, WA3, Ov},
        {pc, instr, r, b, imm, (trap && ov) ? 5'd0 : wa, ov});
  endtask

  task automatic chk_bubble(input string tag);
    chk(tag, {PC3, Instr3, Result3, B3, imm32_3, WA3, Ov}, '0);
  endtask

  // Update the HI/LO model for a completed mult/multu/div/divu.
  task automatic mdu_model(input logic [5:0] fn, input logic [31:0] a, b);
    longint x, y, p, q, rm;
    logic [63:0] pu;
    if (fn == 6'h18 || fn == 6'h1A) begin x = $signed(a); y = $signed(b); end
    else begin x = a; y = b; end
    if (fn == 6'h18) begin p = x * y; hi_m = p[63:32]; lo_m = p[31:0]; end
    else if (fn == 6'h19) begin pu = {32'h0, a} * {32'h0, b}; hi_m = pu[63:32]; lo_m = pu[31:0]; end
    else if (b != 0) begin q = x / y; rm = x % y; hi_m = rm[31:0]; lo_m = q[31:0]; end
  endtask

  // Issue an MDU op followed by a nop, then count Busy cycles.
  task automatic run_mdu(input string tag, input logic [5:0] fn, input logic [31:0] a, b);
    int n;
    drive(rt(fn, 0), a, b, 0, 0);
    step();
    drive(32'h0, 0, 0, 0, 0);
    n = 0;
    while (Busy && n < 20) begin n++; step(); end
    chk(tag, n, (fn == 6'h1A || fn == 6'h1B) ? 10 : 5);
    mdu_model(fn, a, b);
  endtask

  initial begin
    logic [31:0] a, b, imm, ins;
    logic [15:0] h;
    int n, k;

    reset = 1; IntReq = 0; hi_m = 0; lo_m = 0;
    drive(32'h0, 0, 0, 0, 0);
    step(); step();
    chk("reset_state", {PC3, Instr3, Result3, B3, imm32_3, WA3, Ov, Busy, Stall}, '0);
    reset = 0;

    exec_alu("add_ovf", rt(6'h20, 0), 32'h7FFFFFFF, 32'h1, 0, 5'd8);
    chk("add_ovf_result", {Result3, Ov, WA3}, {32'h80000000, 1'b1, 5'd0});

    exec_alu("sra31", rt(6'h03, 5'd31), 0, 32'h80000000, 0, 5'd3);
    chk("sra31_result", Result3, 32'hFFFFFFFF);
    exec_alu("lw_addr_ovf", it(6'h23), 32'h7FFFFFFC, 0, 32'h8, 5'd4);
    chk("lw_ov", {Ov, WA3}, {1'b1, 5'd4});

    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 25);
      a = $urandom; b = $urandom; h = 16'($urandom);
      if (k < 16) begin
        ins = rt(r_fns[k], 5'($urandom));
        imm = $urandom;
      end else begin
        ins = it(i_ops[k-16]);
        imm = (i_ops[k-16] inside {6'h0C, 6'h0D, 6'h0E, 6'h0F}) ? {16'h0, h} : {{16{h[15]}}, h};
      end
      if (i % 5 == 0) a = 32'h7FFFFFF0 ^ {28'h0, 4'($urandom)};
      exec_alu($sformatf("alu_rand_%0d", i), ins, a, b, imm, 5'($urandom_range(1, 31)));
    end

    // mult then mflo directly behind it: stalled with bubbles while Busy
    drive(rt(6'h18, 0), 32'hFFFFFFFE, 32'd3, 0, 0);
    step();
    drive(rt(6'h12, 0), 0, 0, 0, 5'd9);
    n = 0;
    while (Busy && n < 20) begin
      chk("mult_stall", Stall, 1'b1);
      step();
      chk_bubble("mult_bubble");
      n++;
    end
    chk("mult_busy_cycles", n, 5);
    chk("mflo_no_stall", Stall, 1'b0);
    step();
    chk("mflo_after_mult", {Result3, WA3}, {32'hFFFFFFFA, 5'd9});
    mdu_model(6'h18, 32'hFFFFFFFE, 32'd3);
    exec_alu("mfhi_after_mult", rt(6'h10, 0), 0, 0, 0, 5'd10);
    chk("mfhi_const", Result3, 32'hFFFFFFFF);

    run_mdu("div_busy", 6'h1A, -32'sd7, 32'd2);
    exec_alu("div_lo", rt(6'h12, 0), 0, 0, 0, 5'd2);
    chk("div_lo_const", Result3, 32'hFFFFFFFD);
    exec_alu("div_hi", rt(6'h10, 0), 0, 0, 0, 5'd2);
    chk("div_hi_const", Result3, 32'hFFFFFFFF);

    run_mdu("divu0_busy", 6'h1B, 32'd1234, 32'd0);
    exec_alu("divu0_hi", rt(6'h10, 0), 0, 0, 0, 5'd2);
    exec_alu("divu0_lo", rt(6'h12, 0), 0, 0, 0, 5'd2);

    for (int i = 0; i < 8; i++) begin
      k = $urandom_range(0, 3);
      a = $urandom; b = $urandom;
      if (i == 3) begin a = 32'h80000000; b = 32'hFFFFFFFF; k = 2; end
      if (k >= 2 && i % 2 == 1) b = b >> $urandom_range(16, 31);
      run_mdu($sformatf("mdu_rand_busy_%0d", i), 6'h18 + 6'(k), a, b);
      exec_alu($sformatf("mdu_rand_hi_%0d", i), rt(6'h10, 0), 0, 0, 0, 5'd5);
      exec_alu($sformatf("mdu_rand_lo_%0d", i), rt(6'h12, 0), 0, 0, 0, 5'd6);
    end

    // mthi/mtlo, and a flushed mthi that must not commit
    a = $urandom; b = $urandom;
    drive(rt(6'h11, 0), a, 0, 0, 0); step();
    drive(rt(6'h13, 0), b, 0, 0, 0); step();
    hi_m = a; lo_m = b;
    IntReq = 1;
    drive(rt(6'h11, 0), ~a, 0, 0, 0); step();
    chk_bubble("mthi_flush_bubble");
    IntReq = 0;
    exec_alu("mthi_hi", rt(6'h10, 0), 0, 0, 0, 5'd7);
    exec_alu("mtlo_lo", rt(6'h12, 0), 0, 0, 0, 5'd7);

    // IntReq in the same cycle as multu: no start, bubble, HI/LO kept
    IntReq = 1;
    drive(rt(6'h19, 0), 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    step();
    chk("int_multu_busy", Busy, 1'b0);
    chk_bubble("int_multu_bubble");
    IntReq = 0;
    exec_alu("int_multu_hi", rt(6'h10, 0), 0, 0, 0, 5'd1);
    exec_alu("int_multu_lo", rt(6'h12, 0), 0, 0, 0, 5'd1);

    // IntReq while an op runs: it keeps going to completion
    drive(rt(6'h19, 0), 32'h12345678, 32'h9ABCDEF0, 0, 0);
    step();
    drive(32'h0, 0, 0, 0, 0);
    n = 0;
    while (Busy && n < 20) begin
      IntReq = (n < 2);
      step();
      n++;
    end
    IntReq = 0;
    chk("int_running_busy_cycles", n, 5);
    mdu_model(6'h19, 32'h12345678, 32'h9ABCDEF0);
    exec_alu("int_running_hi", rt(6'h10, 0), 0, 0, 0, 5'd1);

    // reset on the 3rd Busy cycle of a div
    drive(rt(6'h1A, 0), 32'd1000, 32'd7, 0, 0);
    step();
    drive(rt(6'h12, 0), 0, 0, 0, 5'd3);
    step(); step();
    chk("pre_reset_busy", Busy, 1'b1);
    reset = 1;
    step();
    chk("reset_mid_div", {PC3, Instr3, Result3, B3, imm32_3, WA3, Ov, Busy}, '0);
    reset = 0;
    hi_m = 0; lo_m = 0;
    exec_alu("reset_lo", rt(6'h12, 0), 0, 0, 0, 5'd3);
    exec_alu("reset_hi", rt(6'h10, 0), 0, 0, 0, 5'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
